opcode_byte_unpacker: RTL
=========================

// Module: opcode_byte_unpacker
// PURPOSE
//   Receive side of the 64-bit Opcode_st frame. Reassembles an 8-byte stream from the host link
//   (UART RX byte FIFO) into one Opcode_p::Opcode_st. Validates the op field.
//   Hands the opcode to the motion dispatcher over a 1-deep valid/ready output register.
//   Drops stalled partial frames after an inter-byte timeout so the link resynchronises.
// PARAMETERS
//   TIMEOUT_CYCLES  100000  idle clk cycles allowed between accepted bytes of one frame (>=2)
//   CHECK_OP        1       1: reject frames whose op is not in Opcode_t (0..3); 0: pass all ops
// PORTS
//   clk          in   1        system clock; all logic on rising edge
//   reset        in   1        asynchronous, active-high reset
//   in_byte      in   8        frame byte from link
//   in_valid     in   1        in_byte valid
//   in_ready     out  1        unpacker can accept in_byte this cycle
//   opcode       out  Opcode_st  assembled opcode (op 8, arg1..4 12 each, flags 8 = 64 bits)
//   out_valid    out  1        opcode valid, held until out_ready
//   out_ready    in   1        dispatcher accepts opcode
//   frame_busy   out  1        partial frame in progress (state COLLECT)
//   err_timeout  out  1        1-cycle pulse: partial frame discarded on timeout
//   err_bad_op   out  1        1-cycle pulse: complete frame discarded, op > 3 (CHECK_OP=1)
// BEHAVIOUR
//   Reset (async, active-high):
//     state=IDLE, byte index=0, gap counter=0, out_valid=0, opcode all-zero,
//     err_*=0, frame_busy=0; in_ready=1 once reset deasserts.
//   Byte transfer: occurs when in_valid && in_ready on a rising edge. in_ready = (state != HOLD).
//   Frame format, big-endian, byte 0 first:
//     b0 = op
//     b1..b6 = A[47:0] with A = {b1,b2,b3,b4,b5,b6}
//       arg1=A[47:36], arg2=A[35:24], arg3=A[23:12], arg4=A[11:0]
//     b7 = flags
//   States:
//     IDLE
//       - Byte accepted -> store b0, idx=1, gap=0 -> COLLECT.
//     COLLECT
//       - Byte accepted -> store at idx, idx++, gap=0.
//       - No byte this cycle -> gap++.
//       - 8th byte (idx 7) accepted:
//           op valid or CHECK_OP=0 -> load opcode register, out_valid=1 next cycle -> HOLD.
//           else -> err_bad_op pulse next cycle -> IDLE; opcode register and out_valid unchanged.
//       - gap reaches TIMEOUT_CYCLES with no byte:
//           discard partial frame, err_timeout pulse next cycle, idx=0 -> IDLE.
//       - Byte accepted in the same cycle gap would reach the limit: byte wins, gap clears, no timeout.
//     HOLD
//       - out_valid=1; opcode stable.
//       - out_ready -> out_valid=0 next cycle -> IDLE; in_ready=1 that same next cycle.
//       - in_valid ignored (in_ready=0); no timeout counting.
//   Latency: out_valid rises 1 clk after the 8th byte is accepted.
//     Minimum frame period is 9 clk: 8 accepts + 1 HOLD cycle with out_ready tied high.
//   opcode register is written only on a good frame; retains its last value otherwise.
//   reset mid-frame or in HOLD: immediately returns to the reset state; partial or held frame lost; no error pulse.
//   Gap counter width: $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
// TESTING
//   1) Reset, send 01 12 34 56 78 9A BC 5A back-to-back, out_ready=1 ->
//        op=01 arg1=123 arg2=456 arg3=789 arg4=ABC flags=5A;
//        out_valid high exactly 1 clk, 1 clk after last byte.
//   2) Same frame with out_ready=0 for 20 clk ->
//        in_ready=0 and opcode stable throughout; one transfer when out_ready rises;
//        next byte accepted the following cycle.
//   3) Frame with b0=07, CHECK_OP=1 ->
//        err_bad_op 1-clk pulse; no out_valid; opcode keeps the previous value;
//        next good frame decodes correctly.
//   4) TIMEOUT_CYCLES=16: send 3 bytes, then wait ->
//        err_timeout pulse after 16 idle cycles; frame_busy falls;
//        a following full frame decodes with byte 0 as op.
//   5) Gap of exactly TIMEOUT_CYCLES-1 idle cycles between bytes ->
//        no timeout; frame decodes. Byte arriving on the limit cycle -> accepted, no err_timeout.
//   6) Assert reset after 5 bytes and in HOLD ->
//        all outputs return to reset values asynchronously; no error pulses;
//        a new frame after reset decodes correctly.

Source files
------------

// File: rtl/opcode_byte_unpacker.sv
// Purpose: reassemble an 8-byte host-link stream into one Opcode_st and validate its op field.
// Latency: out_valid rises 1 clk after the 8th byte is accepted; minimum frame period is 9 clk.
// Backpressure: in_ready drops while an opcode is held; held until out_ready, stalled frames time out.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   in_byte/in_valid/in_ready   byte stream from the link (valid/ready)
//   opcode/out_valid/out_ready  assembled opcode to the dispatcher (1-deep, valid/ready)
//   frame_busy              a partial frame is being collected
//   err_timeout             1-clk pulse: partial frame dropped after an inter-byte gap
//   err_bad_op              1-clk pulse: complete frame dropped because op is not a known opcode

`timescale 1ns/1ps

package Opcode_p;

  // Highest op value that is a member of Opcode_t.
  localparam logic [7:0] OP_MAX = 8'd3;

  typedef struct packed {
    logic [7:0]  op;
    logic [11:0] arg1;
    logic [11:0] arg2;
    logic [11:0] arg3;
    logic [11:0] arg4;
    logic [7:0]  flags;
  } Opcode_st;

endpackage

module opcode_byte_unpacker #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          CHECK_OP       = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output Opcode_p::Opcode_st opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_busy,
  output logic               err_timeout,
  output logic               err_bad_op
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  // Gap value at which one more idle cycle expires the frame.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Bytes 0..6 of the frame in progress; byte 7 is taken straight from in_byte.
  logic [6:0][7:0]  frame_q;

  logic             accept;
  logic             store_en;
  logic             load_en;
  logic             op_ok;
  logic             err_timeout_d;
  logic             err_bad_op_d;
  logic [47:0]      a_word;

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign frame_busy = (state_q == COLLECT);

  assign accept = in_valid && in_ready;

  // b1..b6 form one big-endian 48-bit word that is split into four 12-bit args.
  assign a_word = {frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5], frame_q[6]};

  assign op_ok = !CHECK_OP || (frame_q[0] <= Opcode_p::OP_MAX);

  // Next-state and control.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    store_en      = 1'b0;
    load_en       = 1'b0;
    err_timeout_d = 1'b0;
    err_bad_op_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          store_en = 1'b1;
          idx_d    = 3'd1;
          gap_d    = '0;
          state_d  = COLLECT;
        end
      end

      COLLECT: begin
        if (accept) begin
          // A byte always wins over the timeout, even on the limit cycle.
          gap_d = '0;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (op_ok) begin
              load_en = 1'b1;
              state_d = HOLD;
            end else begin
              err_bad_op_d = 1'b1;
              state_d      = IDLE;
            end
          end else begin
            store_en = 1'b1;
            idx_d    = idx_q + 3'd1;
          end
        end else if (gap_q >= GAP_LAST) begin
          // This idle cycle is the TIMEOUT_CYCLES-th one; the compare also
          // keeps the counter from ever running past the limit.
          err_timeout_d = 1'b1;
          idx_d         = 3'd0;
          gap_d         = '0;
          state_d       = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      HOLD: begin
        // Input is stalled here, so the gap counter is left alone.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
        gap_d   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Frame byte buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else if (store_en) begin
      frame_q[idx_q] <= in_byte;
    end
  end

  // Output opcode register: written only by a frame that passed the op check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode <= '0;
    end else if (load_en) begin
      opcode <= {frame_q[0], a_word, in_byte};
    end
  end

  // Error pulses, registered so they line up with the cycle after the decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_timeout <= 1'b0;
      err_bad_op  <= 1'b0;
    end else begin
      err_timeout <= err_timeout_d;
      err_bad_op  <= err_bad_op_d;
    end
  end

endmodule
